// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor. Each of the STAGES stages ripple-adds one
// SW-bit slice. Slices not yet added travel forward, and completed partial sums
// accumulate, so the final stage presents an aligned result with its flags.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SW = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] b_inv;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_inv    = b ^ {WIDTH{sub}};

    // Ripple chain of full adders over one slice; returns {carry_out, sum}.
    function automatic logic [SW:0] ripple(input logic [SW-1:0] x,
                                           input logic [SW-1:0] y,
                                           input logic          cin);
        logic [SW:0] r;
        logic        c;
        r = '0;
        c = cin;
        for (int unsigned i = 0; i < SW; i++) begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        r[SW] = c;
        return r;
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned DONE = (k + 1) * SW;
        localparam int unsigned REM  = WIDTH - DONE;

        logic            v_in;
        logic            c_in;
        logic [SW-1:0]   a_sl;
        logic [SW-1:0]   b_sl;
        logic [SW:0]     res;
        logic [DONE-1:0] s_d;
        logic            v_q;
        logic            c_q;
        logic [DONE-1:0] s_q;

        // Remaining operand slices are kept shifted down, so the slice this
        // stage works on always sits in the low SW bits of the previous stage.
        if (k == 0) begin : g_src
            assign v_in = in_valid;
            assign c_in = sub;
            assign a_sl = a[SW-1:0];
            assign b_sl = b_inv[SW-1:0];
            assign s_d  = res[SW-1:0];
        end else begin : g_src
            assign v_in = g_stage[k-1].v_q;
            assign c_in = g_stage[k-1].c_q;
            assign a_sl = g_stage[k-1].g_fwd.a_q[SW-1:0];
            assign b_sl = g_stage[k-1].g_fwd.b_q[SW-1:0];
            assign s_d  = {res[SW-1:0], g_stage[k-1].s_q};
        end

        assign res = ripple(a_sl, b_sl, c_in);

        // Stage valid, inter-slice carry and accumulated partial sum.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_in;
                c_q <= res[SW];
                s_q <= s_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-1:0] a_d;
            logic [REM-1:0] b_d;
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;

            if (k == 0) begin : g_in
                assign a_d = a[WIDTH-1:SW];
                assign b_d = b_inv[WIDTH-1:SW];
            end else begin : g_in
                assign a_d = g_stage[k-1].g_fwd.a_q[REM+SW-1:SW];
                assign b_d = g_stage[k-1].g_fwd.b_q[REM+SW-1:SW];
            end

            // Carry the not-yet-added operand slices forward.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic zero_d;
            logic ovf_q;
            logic zero_q;

            // Carry into the MSB recovered as a ^ b' ^ sum at that bit.
            assign ovf_d  = (a_sl[SW-1] ^ b_sl[SW-1] ^ res[SW-1]) ^ res[SW];
            assign zero_d = (s_d == '0);

            // Flags registered alongside the final aligned sum.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign overflow  = g_stage[STAGES-1].g_last.ovf_q;
    assign zero      = g_stage[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four configurations run side by side, each with a
// queue-based reference model, a per-cycle compare process and directed cases.
module tb_pipelined_adder;

    typedef struct packed {
        logic        c;
        logic        v;
        logic        z;
        logic [63:0] s;
    } res_t;

    typedef struct {
        res_t r;
        int   t;
        bit   lat;
    } entry_t;

    logic clock = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_done = 0;

    always #5 clock = ~clock;

    task automatic check(input bit ok, input string nm,
                         input logic [66:0] act, input logic [66:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Arithmetic reference: w-bit add or subtract with flags from their definitions.
    function automatic res_t model(input logic [63:0] x_in, input logic [63:0] y_in,
                                   input logic s, input int unsigned w);
        logic [63:0] mask;
        logic [63:0] x;
        logic [63:0] y;
        logic [64:0] ext;
        logic        sx;
        logic        sy;
        logic        sr;
        res_t        r;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = x_in & mask;
        y = y_in & mask;
        if (s) begin
            r.s = (x - y) & mask;
            r.c = (x >= y);
        end else begin
            ext = {1'b0, x} + {1'b0, y};
            r.s = ext[63:0] & mask;
            r.c = ext[w];
        end
        sx = x[w-1];
        sy = y[w-1];
        sr = r.s[w-1];
        r.v = s ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
        r.z = (r.s == 64'd0);
        return r;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_h
        localparam int W = (g == 0) ? 32 : (g == 1) ? 8 : (g == 2) ? 16 : 64;
        localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;

        logic         rst_n = 1'b0;
        logic         in_valid = 1'b0;
        logic         in_ready;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic         sub = 1'b0;
        logic         out_valid;
        logic         out_ready = 1'b1;
        logic [W-1:0] sum;
        logic         cout;
        logic         overflow;
        logic         zero;

        int           cyc = 0;
        bit           lat_mode = 1'b1;
        bit           pat_en = 1'b0;
        int           popped = 0;
        entry_t       q[$];

        pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
            .clock    (clock),
            .reset    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .sum      (sum),
            .cout     (cout),
            .overflow (overflow),
            .zero     (zero)
        );

        always @(posedge clock) cyc <= cyc + 1;

        // out_ready follows 1,0,0,1 while the pattern is enabled, else stays 1.
        initial begin
            int ph = 0;
            forever begin
                @(posedge clock);
                #1;
                out_ready = pat_en ? (ph == 0 || ph == 3) : 1'b1;
                ph = (ph + 1) % 4;
            end
        end

        // Compare process: runs every negedge, checks outputs against the queue.
        initial begin
            logic         stalled = 1'b0;
            logic [W+3:0] held = '0;
            logic [W+3:0] now_o;
            entry_t       e;
            forever begin
                @(negedge clock);
                now_o = {out_valid, cout, overflow, zero, sum};
                if (!rst_n) begin
                    q.delete();
                    stalled = 1'b0;
                    check(now_o == '0, $sformatf("c%0d_reset_outputs", g), 67'(now_o), 67'd0);
                end else begin
                    check(in_ready == !(out_valid && !out_ready), $sformatf("c%0d_in_ready", g),
                          67'(in_ready), 67'(!(out_valid && !out_ready)));
                    if (stalled)
                        check(now_o == held, $sformatf("c%0d_hold", g), 67'(now_o), 67'(held));
                    if (out_valid) begin
                        if (q.size() == 0) begin
                            check(1'b0, $sformatf("c%0d_stale_result", g), 67'(sum), 67'd0);
                        end else begin
                            e = q[0];
                            check({cout, overflow, zero, 64'(sum)} == e.r, $sformatf("c%0d_result", g),
                                  {cout, overflow, zero, 64'(sum)}, e.r);
                            if (e.lat)
                                check(cyc - e.t == S, $sformatf("c%0d_latency", g),
                                      67'(cyc - e.t), 67'(S));
                            if (out_ready) begin
                                void'(q.pop_front());
                                popped++;
                            end
                        end
                    end
                    stalled = out_valid && !out_ready;
                    held = now_o;
                    if (in_valid && in_ready) begin
                        e.r = model(64'(a), 64'(b), sub, W);
                        e.t = cyc;
                        e.lat = lat_mode;
                        q.push_back(e);
                    end
                end
            end
        end

        task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
            bit acc = 1'b0;
            int guard = 0;
            in_valid = 1'b1;
            a = av;
            b = bv;
            sub = sv;
            while (!acc && guard < 200) begin
                @(negedge clock);
                acc = in_ready;
                @(posedge clock);
                #1;
                guard++;
            end
            if (!acc) check(1'b0, $sformatf("c%0d_accept_timeout", g), 67'd0, 67'd1);
        endtask

        task automatic drain();
            int guard = 0;
            in_valid = 1'b0;
            while (q.size() != 0 && guard < 300) begin
                @(posedge clock);
                guard++;
            end
            #1;
            check(q.size() == 0, $sformatf("c%0d_drain", g), 67'(q.size()), 67'd0);
        endtask

        // Driver: directed cases, backpressure ordering run, mid-flight reset.
        initial begin
            logic [W-1:0] ones;
            logic [W-1:0] one;
            logic [W-1:0] minv;
            logic [63:0]  r1;
            logic [63:0]  r2;
            int           base;
            ones = '1;
            one  = W'(1);
            minv = one << (W - 1);
            repeat (3) @(posedge clock);
            #1;
            rst_n = 1'b1;
            @(posedge clock);
            #1;

            send((one << (W / 2)) - one, one, 1'b0);
            send(~minv, one, 1'b0);
            send(ones, one, 1'b0);
            send(W'(5), W'(7), 1'b1);
            send(minv, one, 1'b1);
            drain();

            lat_mode = 1'b0;
            pat_en = 1'b1;
            base = popped;
            for (int i = 0; i < 16; i++) begin
                r1 = {$urandom(), $urandom()};
                r2 = {$urandom(), $urandom()};
                send(r1[W-1:0], r2[W-1:0], 1'($urandom_range(0, 1)));
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clock);
                    #1;
                end
            end
            drain();
            check(popped - base == 16, $sformatf("c%0d_count", g), 67'(popped - base), 67'd16);
            pat_en = 1'b0;
            repeat (2) @(posedge clock);
            #1;

            lat_mode = 1'b1;
            for (int i = 0; i < 3; i++) begin
                r1 = {$urandom(), $urandom()};
                send(r1[W-1:0], W'(i + 1), 1'b0);
            end
            in_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            check({out_valid, cout, overflow, zero, sum} == '0, $sformatf("c%0d_async_clear", g),
                  67'({out_valid, cout, overflow, zero, sum}), 67'd0);
            @(posedge clock);
            #1;
            rst_n = 1'b1;
            @(posedge clock);
            #1;
            send(ones, W'(2), 1'b0);
            drain();
            n_done++;
        end
    end

    initial begin
        res_t r;
        r = model(64'h0000FFFF, 64'h1, 1'b0, 32);
        check(r == {1'b0, 1'b0, 1'b0, 64'h00010000}, "model_chunk_carry", r, {3'b000, 64'h00010000});
        r = model(64'h7FFFFFFF, 64'h1, 1'b0, 32);
        check(r == {1'b0, 1'b1, 1'b0, 64'h80000000}, "model_pos_overflow", r, {3'b010, 64'h80000000});
        r = model(64'hFFFFFFFF, 64'h1, 1'b0, 32);
        check(r == {1'b1, 1'b0, 1'b1, 64'h0}, "model_wrap_zero", r, {3'b101, 64'h0});
        r = model(64'h5, 64'h7, 1'b1, 32);
        check(r == {1'b0, 1'b0, 1'b0, 64'hFFFFFFFE}, "model_sub_borrow", r, {3'b000, 64'hFFFFFFFE});
        r = model(64'h80000000, 64'h1, 1'b1, 32);
        check(r == {1'b1, 1'b1, 1'b0, 64'h7FFFFFFF}, "model_sub_overflow", r, {3'b110, 64'h7FFFFFFF});

        for (int i = 0; i < 20000 && n_done < 4; i++) @(posedge clock);
        if (n_done < 4) check(1'b0, "global_timeout", 67'(n_done), 67'd4);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
